// File: rtl/cpu_controller.sv
// Instruction-sequencing FSM for the 16-bit register-file/ALU datapath.
// Holds one instruction in IR and steps the datapath through read, compute and write-back cycles.
module cpu_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic        illegal,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] datapath_out
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WR_IMM, S_GETA, S_GETB, S_ALU, S_CMP, S_WR_RD
  } state_t;

  typedef enum logic [2:0] {
    I_MOVI, I_MOVR, I_ADD, I_CMP, I_AND, I_MVN, I_ILL
  } instr_t;

  state_t      state, state_nxt;
  logic [15:0] ir;
  instr_t      instr;

  function automatic logic signed [15:0] sext_imm8(input logic signed [7:0] imm8);
    return {{8{imm8[7]}}, imm8};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (state == S_WAIT && load)
        ir <= in;
    end
  end

  // Opcode/op decode of the held instruction
  always_comb begin
    instr = I_ILL;
    case (ir[15:11])
      5'b11010: instr = I_MOVI;
      5'b11000: instr = I_MOVR;
      5'b10100: instr = I_ADD;
      5'b10101: instr = I_CMP;
      5'b10110: instr = I_AND;
      5'b10111: instr = I_MVN;
      default:  instr = I_ILL;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:   state_nxt = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        case (instr)
          I_MOVI:               state_nxt = S_WR_IMM;
          I_MOVR, I_MVN:        state_nxt = S_GETB;
          I_ADD, I_AND, I_CMP:  state_nxt = S_GETA;
          default:              state_nxt = S_WAIT;
        endcase
      end
      S_GETA:   state_nxt = S_GETB;
      S_GETB:   state_nxt = (instr == I_CMP) ? S_CMP : S_ALU;
      S_ALU:    state_nxt = S_WR_RD;
      S_CMP:    state_nxt = S_WAIT;
      S_WR_RD:  state_nxt = S_WAIT;
      S_WR_IMM: state_nxt = S_WAIT;
      default:  state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    w        = 1'b0;
    illegal  = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    case (state)
      S_WAIT:   w = 1'b1;
      S_DECODE: illegal = (instr == I_ILL);
      S_GETA: begin
        readnum = ir[10:8];
        loada   = 1'b1;
      end
      S_GETB: begin
        readnum = ir[2:0];
        loadb   = 1'b1;
      end
      S_ALU: begin
        shift = ir[4:3];
        asel  = (instr == I_MOVR) || (instr == I_MVN);
        loadc = 1'b1;
        case (instr)
          I_AND:   ALUop = 2'b10;
          I_MVN:   ALUop = 2'b11;
          default: ALUop = 2'b00;
        endcase
      end
      S_CMP: begin
        shift = ir[4:3];
        ALUop = 2'b01;
        loads = 1'b1;
      end
      S_WR_RD: begin
        writenum = ir[7:5];
        write    = 1'b1;
      end
      S_WR_IMM: begin
        writenum = ir[10:8];
        vsel     = 1'b1;
        write    = 1'b1;
      end
      default: w = 1'b0;
    endcase
  end

  assign datapath_out = sext_imm8(ir[7:0]);

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed scenarios plus random instruction streams,
// checked cycle by cycle against a micro-operation list built from each instruction.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in_v = 16'h0000;
  logic        load = 1'b0;
  logic        s = 1'b0;
  logic        w, illegal, write, loada, loadb, loadc, loads, asel, bsel, vsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [35:0] exp_q[$];
  logic [35:0] exp_wait;
  logic [15:0] cur_ir = 16'h0000;

  cpu_controller dut (
    .clk(clk), .reset_n(reset_n), .in(in_v), .load(load), .s(s),
    .w(w), .illegal(illegal), .readnum(readnum), .writenum(writenum),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
    .datapath_out(datapath_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  wire [35:0] obs = {w, illegal, readnum, writenum, write, loada, loadb, loadc,
                     loads, asel, bsel, vsel, shift, ALUop, datapath_out};

  function automatic logic [35:0] vec(input logic w_e, input logic ill_e,
                                      input logic [2:0] rdn, input logic [2:0] wrn,
                                      input logic wr, input logic la, input logic lb,
                                      input logic lc, input logic ls, input logic as,
                                      input logic vs, input logic [1:0] sh,
                                      input logic [1:0] op, input logic [15:0] dp);
    return {w_e, ill_e, rdn, wrn, wr, la, lb, lc, ls, as, 1'b0, vs, sh, op, dp};
  endfunction

  function automatic logic [15:0] sext8(input logic [15:0] ir);
    return {{8{ir[7]}}, ir[7:0]};
  endfunction

  // Expected datapath micro-operations for one instruction, one entry per busy cycle
  task automatic build_expect(input logic [15:0] ir);
    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh;
    logic [15:0] imm;
    bit movi, movr, add, cmp, andi, mvn, legal;
    logic [1:0]  aluop;
    rn = ir[10:8]; rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
    imm  = sext8(ir);
    movi = (ir[15:13] == 3'b110) && (ir[12:11] == 2'b10);
    movr = (ir[15:13] == 3'b110) && (ir[12:11] == 2'b00);
    add  = (ir[15:13] == 3'b101) && (ir[12:11] == 2'b00);
    cmp  = (ir[15:13] == 3'b101) && (ir[12:11] == 2'b01);
    andi = (ir[15:13] == 3'b101) && (ir[12:11] == 2'b10);
    mvn  = (ir[15:13] == 3'b101) && (ir[12:11] == 2'b11);
    legal = movi | movr | add | cmp | andi | mvn;
    exp_q.delete();
    exp_q.push_back(vec(0, !legal, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, imm));
    if (movi)
      exp_q.push_back(vec(0, 0, 0, rn, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, imm));
    if (add | andi | cmp)
      exp_q.push_back(vec(0, 0, rn, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, imm));
    if (legal && !movi)
      exp_q.push_back(vec(0, 0, rm, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, imm));
    if (cmp)
      exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, sh, 2'b01, imm));
    if (movr | mvn | add | andi) begin
      aluop = andi ? 2'b10 : (mvn ? 2'b11 : 2'b00);
      exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 1, 0, movr | mvn, 0, sh, aluop, imm));
      exp_q.push_back(vec(0, 0, 0, rd, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, imm));
    end
    exp_wait = vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, imm);
  endtask

  // Starts from a WAIT cycle (sampled #1 after an edge) and ends on the next WAIT cycle
  task automatic run_instr(input logic [15:0] ir, input bit do_load, input bit hold_s,
                           input bit junk, input string name);
    int busy;
    build_expect(do_load ? ir : cur_ir);
    if (do_load) begin
      in_v = ir;
      load = 1'b1;
      cur_ir = ir;
    end
    s = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    s = hold_s;
    busy = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h, required %h", name, i, obs, exp_q[i]);
      end
      if (w === 1'b0) busy++;
      if (junk) begin
        load = 1'($urandom_range(0, 1));
        in_v = 16'($urandom);
        s = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    load = 1'b0;
    s = hold_s;
    n_checks++;
    if (obs !== exp_wait) begin
      n_fail++;
      $display("FAIL %s return-to-wait: got %h, required %h", name, obs, exp_wait);
    end
    n_checks++;
    if (busy !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s busy cycles: got %0d, required %0d", name, busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    logic [35:0] rst_v;
    rst_v = vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== rst_v) begin
      n_fail++;
      $display("FAIL reset_state: got %h, required %h", obs, rst_v);
    end
    reset_n = 1'b1;
    cur_ir = 16'h0000;
    @(posedge clk); #1;
    run_instr(16'h0000, 0, 0, 0, "illegal_ir0");
  endtask

  task automatic test_mov_imm();
    run_instr(16'hD007, 1, 0, 0, "mov_r0_7");
    run_instr(16'hD1FE, 1, 0, 0, "mov_r1_m2");
    n_checks++;
    if (datapath_out !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL mov_r1_m2 datapath_out: got %h, required fffe", datapath_out);
    end
  endtask

  task automatic test_alu_ops();
    run_instr(16'hA148, 1, 0, 0, "add_r2_r1_r0lsl");
    run_instr(16'hA900, 1, 0, 0, "cmp_r1_r0");
    run_instr(16'hB2F1, 1, 0, 0, "and_r7_r2_r1lsr");
    run_instr(16'hB85B, 1, 0, 0, "mvn_r2_r3asr");
    run_instr(16'hC0A4, 1, 0, 0, "mov_r5_r4");
    run_instr(16'hE123, 1, 0, 0, "illegal_111");
  endtask

  task automatic test_reset_mid_add();
    logic [35:0] idle0;
    idle0 = vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'h0000);
    build_expect(16'hA148);
    in_v = 16'hA148; load = 1'b1; s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      load = 1'b0; s = 1'b0;
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL mid_add cycle %0d: got %h, required %h", i, obs, exp_q[i]);
      end
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== idle0) begin
      n_fail++;
      $display("FAIL mid_add async reset: got %h, required %h", obs, idle0);
    end
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    cur_ir = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (obs !== idle0) begin
        n_fail++;
        $display("FAIL after_reset idle %0d: got %h, required %h", i, obs, idle0);
      end
    end
    run_instr(16'hD007, 1, 0, 0, "recover_mov");
  endtask

  task automatic test_back_to_back();
    run_instr(16'hA148, 1, 1, 0, "b2b_add");
    run_instr(16'hD1FE, 1, 1, 0, "b2b_mov");
    run_instr(16'hD1FE, 0, 1, 0, "b2b_repeat");
    run_instr(16'hA900, 1, 0, 1, "busy_inputs_ignored");
    s = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] rv;
    logic [15:0] ir;
    int idle;
    for (int n = 0; n < 40; n++) begin
      rv = $urandom;
      case ($urandom_range(0, 6))
        0: ir = {5'b11010, rv[10:0]};
        1: ir = {5'b11000, rv[10:0]};
        2: ir = {5'b10100, rv[10:0]};
        3: ir = {5'b10101, rv[10:0]};
        4: ir = {5'b10110, rv[10:0]};
        5: ir = {5'b10111, rv[10:0]};
        default: ir = rv[31:16];
      endcase
      run_instr(ir, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), "random");
      idle = $urandom_range(0, 2);
      if (idle > 0) s = 1'b0;
      for (int k = 0; k < idle; k++) begin
        @(posedge clk); #1;
        n_checks++;
        if (obs !== exp_wait) begin
          n_fail++;
          $display("FAIL random idle: got %h, required %h", obs, exp_wait);
        end
      end
    end
    s = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_alu_ops();
    test_reset_mid_add();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
